// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the write-back port arbiter.
//   AW/DW/NREG : register address width, data width, register count
//   FIFO_DEPTH : default entries per requester FIFO
//   REQ_*      : requester indices (lane0, lane1, load unit)
//   wb_entry_t : one queued register write {wa, wd}
package wb_arb_pkg;
    localparam int unsigned AW         = 5;
    localparam int unsigned DW         = 32;
    localparam int unsigned NREG       = 1 << AW;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned NREQ       = 3;

    localparam int unsigned REQ_LANE0  = 0;
    localparam int unsigned REQ_LANE1  = 1;
    localparam int unsigned REQ_LOAD   = 2;

    typedef logic [1:0] req_idx_t;

    typedef struct packed {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } wb_entry_t;

    // Round-robin successor over the three requesters.
    function automatic req_idx_t req_next(input req_idx_t i);
        return (i == req_idx_t'(NREQ - 1)) ? req_idx_t'(0) : i + req_idx_t'(1);
    endfunction
endpackage

// File: rtl/wb_req_fifo.sv
// Per-requester synchronous FIFO of pending register writes.
//   clk, rst_n   : clock, async active-low reset (empties the FIFO)
//   i_push/i_data: enqueue one entry (caller guarantees not full)
//   i_pop        : drop the head entry (caller guarantees not empty)
//   o_head_c     : current head entry
//   o_full_c     : no free slot
//   o_empty_c    : no entry queued
module wb_req_fifo
    import wb_arb_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_push,
    input  wb_entry_t i_data,
    input  logic      i_pop,
    output wb_entry_t o_head_c,
    output logic      o_full_c,
    output logic      o_empty_c
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_head_c  = r_mem[r_rd_ptr];
    assign o_full_c  = (r_count == CW'(DEPTH));
    assign o_empty_c = (r_count == '0);
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares two register-file write ports among lane0, lane1 and the load unit.
//   req_valid/req_ready/req_wa/req_wd : per-producer write handshake (packed per requester)
//   wp0_* / wp1_*                     : registered write-port outputs
//   busy                              : per-register pending-write scoreboard
//   idle                              : nothing queued and no port active
module wb_port_arbiter #(
    parameter int unsigned FIFO_DEPTH = wb_arb_pkg::FIFO_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [2:0]                       req_valid,
    output logic [2:0]                       req_ready,
    input  logic [3*wb_arb_pkg::AW-1:0]      req_wa,
    input  logic [3*wb_arb_pkg::DW-1:0]      req_wd,
    output logic                             wp0_we,
    output logic [wb_arb_pkg::AW-1:0]        wp0_wa,
    output logic [wb_arb_pkg::DW-1:0]        wp0_wd,
    output logic                             wp1_we,
    output logic [wb_arb_pkg::AW-1:0]        wp1_wa,
    output logic [wb_arb_pkg::DW-1:0]        wp1_wd,
    output logic [wb_arb_pkg::NREG-1:0]      busy,
    output logic                             idle
);
    import wb_arb_pkg::*;

    wb_entry_t       w_in   [NREQ];
    wb_entry_t       w_head [NREQ];
    logic [NREQ-1:0] w_full;
    logic [NREQ-1:0] w_empty;
    logic [NREQ-1:0] w_push;
    logic [NREQ-1:0] w_pop;

    req_idx_t        w_scan;
    req_idx_t        w_sel0;
    req_idx_t        w_sel1;
    logic            w_sel0_vld;
    logic            w_sel1_vld;
    logic            w_grant1;
    req_idx_t        w_rr_nxt;
    logic [NREG-1:0] w_busy_nxt;

    req_idx_t        r_rr;
    logic            r_wp0_we;
    logic [AW-1:0]   r_wp0_wa;
    logic [DW-1:0]   r_wp0_wd;
    logic            r_wp1_we;
    logic [AW-1:0]   r_wp1_wa;
    logic [DW-1:0]   r_wp1_wd;
    logic [NREG-1:0] r_busy;

    // Writes to r0 complete the handshake but are never queued.
    for (genvar g = 0; g < NREQ; g++) begin : g_req
        assign w_in[g]   = {req_wa[g*AW +: AW], req_wd[g*DW +: DW]};
        assign w_push[g] = req_valid[g] & ~w_full[g] & (w_in[g].wa != '0);

        wb_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_push    (w_push[g]),
            .i_data    (w_in[g]),
            .i_pop     (w_pop[g]),
            .o_head_c  (w_head[g]),
            .o_full_c  (w_full[g]),
            .o_empty_c (w_empty[g])
        );
    end

    assign req_ready = ~w_full;

    // Rotated-priority scan: first two non-empty heads starting at rr.
    always_comb begin
        w_scan     = r_rr;
        w_sel0     = '0;
        w_sel1     = '0;
        w_sel0_vld = 1'b0;
        w_sel1_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_empty[w_scan]) begin
                if (!w_sel0_vld) begin
                    w_sel0_vld = 1'b1;
                    w_sel0     = w_scan;
                end else if (!w_sel1_vld) begin
                    w_sel1_vld = 1'b1;
                    w_sel1     = w_scan;
                end
            end
            w_scan = req_next(w_scan);
        end

        // Same destination on both ports would race in the regfile; defer the second.
        w_grant1 = w_sel1_vld && (w_head[w_sel1].wa != w_head[w_sel0].wa);

        w_pop = '0;
        if (w_sel0_vld) w_pop[w_sel0] = 1'b1;
        if (w_grant1)   w_pop[w_sel1] = 1'b1;

        w_rr_nxt = r_rr;
        if (w_grant1)        w_rr_nxt = req_next(w_sel1);
        else if (w_sel0_vld) w_rr_nxt = req_next(w_sel0);
    end

    // Scoreboard: clear after the port cycle, then apply enqueues so set wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_wp0_we) w_busy_nxt[r_wp0_wa] = 1'b0;
        if (r_wp1_we) w_busy_nxt[r_wp1_wa] = 1'b0;
        for (int g = 0; g < NREQ; g++) begin
            if (w_push[g]) w_busy_nxt[w_in[g].wa] = 1'b1;
        end
    end

    // Port, round-robin and scoreboard registers; port address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr     <= '0;
            r_wp0_we <= 1'b0;
            r_wp0_wa <= '0;
            r_wp0_wd <= '0;
            r_wp1_we <= 1'b0;
            r_wp1_wa <= '0;
            r_wp1_wd <= '0;
            r_busy   <= '0;
        end else begin
            r_rr     <= w_rr_nxt;
            r_busy   <= w_busy_nxt;
            r_wp0_we <= w_sel0_vld;
            r_wp1_we <= w_grant1;
            if (w_sel0_vld) begin
                r_wp0_wa <= w_head[w_sel0].wa;
                r_wp0_wd <= w_head[w_sel0].wd;
            end
            if (w_grant1) begin
                r_wp1_wa <= w_head[w_sel1].wa;
                r_wp1_wd <= w_head[w_sel1].wd;
            end
        end
    end

    assign wp0_we = r_wp0_we;
    assign wp0_wa = r_wp0_wa;
    assign wp0_wd = r_wp0_wd;
    assign wp1_we = r_wp1_we;
    assign wp1_wa = r_wp1_wa;
    assign wp1_wd = r_wp1_wd;
    assign busy   = r_busy;
    assign idle   = (&w_empty) & ~r_wp0_we & ~r_wp1_we;
endmodule
